// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: state encoding, configuration
// legality and the two's-complement magnitude helper.
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ZERO = 3'd1,
        S_BUSY = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int MAX_W = 64;

    function automatic bit steps_legal(input int steps, input int width);
        return ((steps == 1) || (steps == 2) || (steps == 4)) &&
               (width >= 8) && (width <= MAX_W) &&
               ((width % 2) == 0) && ((width % steps) == 0);
    endfunction

    // Conditional negate; callers zero-extend into MAX_W and truncate back.
    function automatic logic [MAX_W-1:0] mag(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit and
// subtract the divisor if it fits.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem_i < dvs_i, so a non-negative trial always fits in WIDTH bits and
    // bit WIDTH of the trial is a clean borrow flag.
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, dvs_i};
        q_o     = ~trial[WIDTH];
        rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_iter_param.sv
// Multi-cycle signed/unsigned integer divider, STEPS restoring steps per clock.
// result = {remainder, quotient}; remainder takes the sign of the dividend.
module div_iter_param
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               annul,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic               busy,
    output logic               ready,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] result
);

    localparam int ITER  = WIDTH / STEPS;
    localparam int CNT_W = $clog2(ITER);

    if (!steps_legal(STEPS, WIDTH)) begin : g_bad_cfg
        $error("div_iter_param: illegal WIDTH/STEPS combination");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic               ready_q, ready_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] res_q, res_d;

    logic [WIDTH-1:0]   rem_chain [STEPS+1];
    logic [STEPS-1:0]   qbits;
    logic               sgn1_in, sgn2_in;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // quo_q starts as the dividend magnitude; dividend bits leave at the top
    // while quotient bits enter at the bottom.
    assign rem_chain[0] = rem_q;
    for (genvar k = 0; k < STEPS; k++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_i (rem_chain[k]),
            .bit_i (quo_q[WIDTH-1-k]),
            .dvs_i (dvs_q),
            .rem_o (rem_chain[k+1]),
            .q_o   (qbits[STEPS-1-k])
        );
    end

    assign sgn1_in = div_signed & opdata1[WIDTH-1];
    assign sgn2_in = div_signed & opdata2[WIDTH-1];
    assign quo_fix = WIDTH'(mag(MAX_W'(quo_q), sign1_q ^ sign2_q));
    assign rem_fix = WIDTH'(mag(MAX_W'(rem_q), sign1_q));

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        sign1_d = sign1_q;
        sign2_d = sign2_q;
        ready_d = ready_q;
        dz_d    = dz_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (start && !annul) begin
                    sign1_d = sgn1_in;
                    sign2_d = sgn2_in;
                    quo_d   = WIDTH'(mag(MAX_W'(opdata1), sgn1_in));
                    dvs_d   = WIDTH'(mag(MAX_W'(opdata2), sgn2_in));
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = (opdata2 == '0) ? S_ZERO : S_BUSY;
                end
            end
            S_ZERO: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    dz_d    = 1'b1;
                    res_d   = '0;
                end
            end
            S_BUSY: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_chain[STEPS];
                    quo_d = {quo_q[WIDTH-STEPS-1:0], qbits};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    dz_d    = 1'b0;
                    res_d   = {rem_fix, quo_fix};
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                    dz_d    = 1'b0;
                    res_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            ready_q <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
            ready_q <= ready_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
        end
    end

    assign busy     = (state_q == S_ZERO) || (state_q == S_BUSY) || (state_q == S_FIX);
    assign ready    = ready_q;
    assign div_zero = dz_q;
    assign result   = res_q;

endmodule

// File: tb/tb_div_iter_param.sv
// Drives six divider configurations (WIDTH 32/16 x STEPS 1/2/4) with shared
// stimulus and compares each against a plain-arithmetic reference model.
module tb_div_iter_param;

    localparam int NDUT   = 6;
    localparam int N_RAND = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        annul;
    logic        div_signed;
    logic [31:0] opdata1;
    logic [31:0] opdata2;

    logic [NDUT-1:0] busy_a;
    logic [NDUT-1:0] ready_a;
    logic [NDUT-1:0] dz_a;
    logic [63:0]     res_a [NDUT];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = (g < 3) ? 32 : 16;
        localparam int S = ((g % 3) == 0) ? 1 : (((g % 3) == 1) ? 2 : 4);
        logic [2*W-1:0] res;
        div_iter_param #(.WIDTH(W), .STEPS(S)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .annul      (annul),
            .div_signed (div_signed),
            .opdata1    (opdata1[W-1:0]),
            .opdata2    (opdata2[W-1:0]),
            .busy       (busy_a[g]),
            .ready      (ready_a[g]),
            .div_zero   (dz_a[g]),
            .result     (res)
        );
        assign res_a[g] = 64'(res);
    end

    function automatic int w_of(input int i);
        return (i < 3) ? 32 : 16;
    endfunction

    function automatic int s_of(input int i);
        return ((i % 3) == 0) ? 1 : (((i % 3) == 1) ? 2 : 4);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: truncating division in 64-bit arithmetic, then wrap to w bits.
    function automatic logic [63:0] ref_div(input int w, input bit sgn,
                                            input logic [31:0] a, input logic [31:0] b);
        longint mask = (longint'(1) << w) - 1;
        longint av, bv, q, r;
        if (sgn) begin
            av = (w == 32) ? longint'($signed(a)) : longint'($signed(a[15:0]));
            bv = (w == 32) ? longint'($signed(b)) : longint'($signed(b[15:0]));
        end else begin
            av = longint'(a) & mask;
            bv = longint'(b) & mask;
        end
        if (bv == 0) return 64'd0;
        q = av / bv;
        r = av % bv;
        return 64'(((r & mask) << w) | (q & mask));
    endfunction

    // The accepting edge is edge 1; ready must first be seen after edge ITER+2
    // (edge 2 for a zero divisor) and held until start drops.
    task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input string name, input bit has_lit, input int lit_dut,
                          input logic [63:0] lit);
        logic [63:0] exp_res [NDUT];
        bit          exp_dz  [NDUT];
        int          lat     [NDUT];
        bit          seen    [NDUT];
        int          nseen;
        logic [31:0] m;
        nseen = 0;
        for (int i = 0; i < NDUT; i++) begin
            m          = (w_of(i) == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            exp_dz[i]  = ((b & m) == 32'd0);
            exp_res[i] = ref_div(w_of(i), sgn, a, b);
            lat[i]     = exp_dz[i] ? 2 : (w_of(i) / s_of(i) + 2);
            seen[i]    = 1'b0;
        end
        @(negedge clk);
        start      = 1'b1;
        annul      = 1'b0;
        div_signed = sgn;
        opdata1    = a;
        opdata2    = b;
        @(posedge clk);
        for (int e = 1; e <= 45 && nseen < NDUT; e++) begin
            if (e > 1) @(posedge clk);
            @(negedge clk);
            if (e == 1) begin
                opdata1    = $urandom;
                opdata2    = $urandom;
                div_signed = ~sgn;
            end
            for (int i = 0; i < NDUT; i++) begin
                if (seen[i]) begin
                    check($sformatf("%s_hold_rdy%0d", name, i), 64'(ready_a[i]), 64'd1);
                    check($sformatf("%s_hold_res%0d", name, i), res_a[i], exp_res[i]);
                end else if (ready_a[i]) begin
                    seen[i] = 1'b1;
                    nseen++;
                    check($sformatf("%s_lat%0d", name, i), 64'(e), 64'(lat[i]));
                    check($sformatf("%s_res%0d", name, i), res_a[i], exp_res[i]);
                    check($sformatf("%s_dz%0d", name, i), 64'(dz_a[i]), 64'(exp_dz[i]));
                    check($sformatf("%s_busy_done%0d", name, i), 64'(busy_a[i]), 64'd0);
                    if (has_lit && i == lit_dut)
                        check($sformatf("%s_lit%0d", name, i), res_a[i], lit);
                end else begin
                    check($sformatf("%s_busy%0d", name, i), 64'(busy_a[i]), 64'd1);
                end
            end
        end
        check({name, "_all_ready"}, 64'(nseen), 64'(NDUT));
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, "_drop_rdy"}, 64'(ready_a), 64'd0);
        check({name, "_drop_dz"}, 64'(dz_a), 64'd0);
        check({name, "_drop_busy"}, 64'(busy_a), 64'd0);
        for (int i = 0; i < NDUT; i++)
            check($sformatf("%s_drop_res%0d", name, i), res_a[i], 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        div_signed = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_ready", 64'(ready_a), 64'd0);
        check("rst_dz", 64'(dz_a), 64'd0);
        check("rst_res0", res_a[0], 64'd0);
        rst = 1'b0;

        run_op(1'b0, 32'd100, 32'd7, "u100_7", 1'b1, 0, 64'h00000002_0000000E);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "sm7_2", 1'b1, 0, 64'hFFFFFFFF_FFFFFFFD);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "s7_m2", 1'b1, 0, 64'h00000001_FFFFFFFD);
        run_op(1'b0, 32'h1234, 32'd0, "dz", 1'b1, 0, 64'd0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_ovf", 1'b1, 0, 64'h00000000_80000000);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "u_min", 1'b1, 0, 64'h80000000_00000000);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h10, "u_s4", 1'b1, 2, 64'h0000000F_0FFFFFFF);

        // Annul on edge 10 of a 100/7 operation.
        @(negedge clk);
        start = 1'b1; div_signed = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
        @(posedge clk);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("annul_pre_busy", 64'(busy_a[0]), 64'd1);
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        check("annul_busy", 64'(busy_a), 64'd0);
        check("annul_ready", 64'(ready_a), 64'd0);
        for (int i = 0; i < NDUT; i++)
            check($sformatf("annul_res%0d", i), res_a[i], 64'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("annul_no_ready", 64'(ready_a[0]), 64'd0);
        end
        run_op(1'b0, 32'd20, 32'd3, "after_annul", 1'b1, 0, 64'h00000002_00000006);

        // start and annul together in IDLE: request must be dropped.
        @(negedge clk);
        start = 1'b1; annul = 1'b1; opdata1 = 32'd5; opdata2 = 32'd1;
        @(posedge clk);
        @(negedge clk);
        check("start_annul_busy", 64'(busy_a), 64'd0);
        start = 1'b0; annul = 1'b0;

        // Asynchronous reset while most instances are busy and one is done.
        @(negedge clk);
        start = 1'b1; div_signed = 1'b0; opdata1 = 32'hDEAD_BEEF; opdata2 = 32'h1234;
        @(posedge clk);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("mid_busy0", 64'(busy_a[0]), 64'd1);
        check("mid_ready5", 64'(ready_a[5]), 64'd1);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check("arst_busy", 64'(busy_a), 64'd0);
        check("arst_ready", 64'(ready_a), 64'd0);
        check("arst_dz", 64'(dz_a), 64'd0);
        for (int i = 0; i < NDUT; i++)
            check($sformatf("arst_res%0d", i), res_a[i], 64'd0);
        #1;
        rst = 1'b0;

        for (int n = 0; n < N_RAND; n++) begin
            logic [31:0] a, b;
            bit          sgn;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = {16'($urandom), 16'h8000}; b = 32'hFFFF_FFFF; end
                3: b = $urandom_range(1, 15);
                4: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(sgn, a, b, "rnd", 1'b0, 0, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
